serial_adder: RTL and testbench

Bit-serial ripple adder: the additive counterpart of the team's combinational full subtractor. It accepts two WIDTH-bit operands and a carry-in on a start strobe, then processes one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It presents the sum and carry-out with a one-cycle done pulse. It sits in the arithmetic datapath where area matters more than latency.

---
 rtl/serial_adder_pkg.sv | 15 +
 rtl/full_adder_cell.sv | 13 +
 rtl/serial_adder.sv | 117 +++++++++++
 tb/tb_serial_adder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: FSM state encoding.
// The optional signed-overflow output is enabled by SERIAL_ADDER_OVF_EN.
package serial_adder_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      RUN  = ST_RUN,
      DONE = ST_DONE
   } state_t;

endpackage

// File: rtl/full_adder_cell.sv
// Single combinational full-adder bit slice used by serial_adder.
module full_adder_cell (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ cin;
   assign co = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one bit per clock, LSB first, through one full-adder cell.
// Define SERIAL_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
   output logic             ovf,
`endif
   output state_t           dbg_state
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] s_sr;
   logic [WIDTH-1:0] s_sr_next;
   logic [WIDTH-1:0] s_msb;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             bit_s;
   logic             bit_co;
   logic             load;

   assign dbg_state = state;

   // Starts are only accepted while idle or in the done cycle (back-to-back).
   assign load = start && ((state == IDLE) || (state == DONE));

   full_adder_cell u_fa (
      .a   (a_sr[0]),
      .b   (b_sr[0]),
      .cin (carry),
      .s   (bit_s),
      .co  (bit_co)
   );

   // New sum bit enters at the MSB; built without slicing so WIDTH=1 works.
   always_comb begin
      s_msb            = '0;
      s_msb[WIDTH-1]   = bit_s;
      s_sr_next        = (s_sr >> 1) | s_msb;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf   <= 1'b0;
`endif
         a_sr  <= '0;
         b_sr  <= '0;
         s_sr  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               done <= 1'b0;
               if (load) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  s_sr  <= '0;
                  carry <= cin;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               a_sr  <= a_sr >> 1;
               b_sr  <= b_sr >> 1;
               s_sr  <= s_sr_next;
               carry <= bit_co;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST) begin
                  sum   <= s_sr_next;
                  cout  <= bit_co;
`ifdef SERIAL_ADDER_OVF_EN
                  // carry still holds the carry into the MSB on this edge
                  ovf   <= carry ^ bit_co;
`endif
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed vectors, expected results queued at start.
// Compile with SERIAL_ADDER_OVF_EN to also check the ovf output.
module tb_serial_adder;
   import serial_adder_pkg::*;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic         ovf;
`endif
   state_t       dbg_state;

   int checks = 0;
   int errors = 0;

   // entry layout: {ovf, cout, sum}
   logic [W+1:0] exp_q[$];

   serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .cout      (cout),
`ifdef SERIAL_ADDER_OVF_EN
      .ovf       (ovf),
`endif
      .dbg_state (dbg_state)
   );

   // clock/reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (rst_n && done) begin
         logic [W+1:0] e;
         check("busy_low_with_done", 32'(busy), 32'd0);
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got done=1 expected no result pending at %0t", $time);
         end else begin
            e = exp_q.pop_front();
            check("sum", 32'(sum), 32'(e[W-1:0]));
            check("cout", 32'(cout), 32'(e[W]));
`ifdef SERIAL_ADDER_OVF_EN
            check("ovf", 32'(ovf), 32'(e[W+1]));
`endif
         end
      end
   end

   // Wait for done, sampling #1 after each rising edge; n counts edges after E0.
   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!done && n < W + 6) begin
         @(posedge clk);
         #1;
         n++;
      end
      check({name, "_latency"}, 32'(n), 32'(W));
   endtask

   // driver: one-cycle start, then scramble inputs to prove they were captured
   task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tc, input logic [W-1:0] es, input logic ec, input logic eo);
      @(negedge clk);
      a = ta; b = tb; cin = tc; start = 1'b1;
      exp_q.push_back({eo, ec, es});
      @(posedge clk);
      #1;
      start = 1'b0;
      a = W'($urandom_range(0, 255));
      b = W'($urandom_range(0, 255));
      cin = 1'($urandom_range(0, 1));
      wait_done(name);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a = '0; b = '0; cin = 1'b0;

      // reset with random inputs
      repeat (3) begin
         @(negedge clk);
         start = 1'($urandom_range(0, 1));
         a = W'($urandom_range(0, 255));
         b = W'($urandom_range(0, 255));
         cin = 1'($urandom_range(0, 1));
      end
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
`ifdef SERIAL_ADDER_OVF_EN
      check("rst_ovf", 32'(ovf), 32'd0);
`endif
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // directed vectors: a, b, cin -> sum, cout, ovf
      run_op("add_05_03", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);
      run_op("add_a5_5a_c", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
      run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
      run_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
      run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

      // ignored starts while busy, then back-to-back start in the done cycle
      @(negedge clk);
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      exp_q.push_back({1'b0, 1'b0, 8'h30});
      @(posedge clk);
      #1;
      start = 1'b0;
      begin
         int n;
         n = 0;
         while (!done && n < W + 6) begin
            @(posedge clk);
            #1;
            n++;
            if (!done) begin
               start = ~start;
               a = 8'hFF; b = 8'hFF; cin = 1'b1;
            end
         end
         check("busy_ignore_latency", 32'(n), 32'(W));
      end
      start = 1'b1;
      a = 8'h01; b = 8'h01; cin = 1'b0;
      exp_q.push_back({1'b0, 1'b0, 8'h02});
      @(posedge clk);
      #1;
      start = 1'b0;
      a = 8'hFF; b = 8'hFF;
      wait_done("back_to_back");

      // reset mid-operation: no done, outputs clear immediately
      @(negedge clk);
      a = 8'h33; b = 8'h44; cin = 1'b0; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_sum", 32'(sum), 32'd0);
      check("abort_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
      check("abort_ovf", 32'(ovf), 32'd0);
`endif
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (W + 3) @(negedge clk);
      check("abort_no_done", 32'(exp_q.size()), 32'd0);

      run_op("after_abort", 8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
